// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file transfer controller: register
// index map, micro-command encodings, default geometry and FSM states.
package regfile_pkg;

  localparam int DEF_REG_COUNT = 11;
  localparam int DEF_REG_WIDTH = 12;
  localparam int DEF_IDX_W     = 4;

  // Register-file index map
  localparam logic [3:0] IDX_R      = 4'd0;
  localparam logic [3:0] IDX_ROW    = 4'd1;
  localparam logic [3:0] IDX_CAT    = 4'd2;
  localparam logic [3:0] IDX_CB     = 4'd3;
  localparam logic [3:0] IDX_RNOW   = 4'd4;
  localparam logic [3:0] IDX_CATNOW = 4'd5;
  localparam logic [3:0] IDX_CBNOW  = 4'd6;
  localparam logic [3:0] IDX_ALPHAP = 4'd7;
  localparam logic [3:0] IDX_BETAP  = 4'd8;
  localparam logic [3:0] IDX_GAMMAP = 4'd9;
  localparam logic [3:0] IDX_TOTAL  = 4'd10;

  typedef enum logic [1:0] {
    OP_MOVE  = 2'd0,
    OP_INC   = 2'd1,
    OP_LOADI = 2'd2,
    OP_CLR   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // MOVE and INC need a read cycle on the source register before writing
  function automatic logic op_reads_src(input op_e op);
    return (op == OP_MOVE) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot select decoder. Indices at or beyond REG_COUNT
// decode to all-zero, which the controller uses as its range check.
module reg_onehot_dec
  import regfile_pkg::*;
#(
  parameter int IDX_W     = DEF_IDX_W,
  parameter int REG_COUNT = DEF_REG_COUNT
) (
  input  logic [IDX_W-1:0]     idx,
  output logic [REG_COUNT-1:0] onehot
);

  // Compare the index against every legal entry; no match leaves all bits low
  always_comb begin
    onehot = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (idx == IDX_W'(i)) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_transfer_ctrl.sv
// Command-driven transfer controller in front of the register file. Turns
// MOVE/INC/LOADI/CLR micro-commands into one-hot read and write cycles and
// is the sole driver of rf_read_en, rf_write_en and rf_datain. The rf_datain
// register doubles as the holding latch for data read back from the file.
module regfile_transfer_ctrl
  import regfile_pkg::*;
#(
  parameter int REG_COUNT = DEF_REG_COUNT,
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [IDX_W-1:0]     cmd_src,
  input  logic [IDX_W-1:0]     cmd_dst,
  input  logic [REG_WIDTH-1:0] cmd_imm,
  output logic [REG_COUNT-1:0] rf_read_en,
  output logic [REG_COUNT-1:0] rf_write_en,
  output logic [REG_WIDTH-1:0] rf_datain,
  input  logic [REG_WIDTH-1:0] rf_dataout,
  output logic                 done,
  output logic                 err
);

  state_e               state_r;
  op_e                  op_r;
  logic [IDX_W-1:0]     dst_r;

  op_e                  cmd_op_s;
  logic [IDX_W-1:0]     dst_idx_s;
  logic [REG_COUNT-1:0] src_oh_s;
  logic [REG_COUNT-1:0] dst_oh_s;
  logic                 needs_src_s;
  logic                 bad_idx_s;

  assign cmd_op_s = op_e'(cmd_op);

  // The destination decoder checks the incoming command while idle and
  // drives the write strobe from the latched destination afterwards.
  assign dst_idx_s = (state_r == ST_IDLE) ? cmd_dst : dst_r;

  reg_onehot_dec #(.IDX_W(IDX_W), .REG_COUNT(REG_COUNT)) u_src_dec (
    .idx    (cmd_src),
    .onehot (src_oh_s)
  );

  reg_onehot_dec #(.IDX_W(IDX_W), .REG_COUNT(REG_COUNT)) u_dst_dec (
    .idx    (dst_idx_s),
    .onehot (dst_oh_s)
  );

  // Range check at acceptance: an all-zero decode means the index is out of range
  always_comb begin
    needs_src_s = op_reads_src(cmd_op_s);
    bad_idx_s   = 1'b0;
    if (dst_oh_s == '0) begin
      bad_idx_s = 1'b1;
    end else if (needs_src_s && (src_oh_s == '0)) begin
      bad_idx_s = 1'b1;
    end else begin
      bad_idx_s = 1'b0;
    end
  end

  // Transfer FSM with all handshake, enable and data outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_MOVE;
      dst_r       <= '0;
      cmd_ready   <= 1'b1;
      rf_read_en  <= '0;
      rf_write_en <= '0;
      rf_datain   <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rf_read_en  <= '0;
          rf_write_en <= '0;
          done        <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            if (bad_idx_s) begin
              // Rejected command is consumed; stay idle and flag it for one cycle
              err       <= 1'b1;
              cmd_ready <= 1'b1;
              state_r   <= ST_IDLE;
            end else begin
              err       <= 1'b0;
              op_r      <= cmd_op_s;
              dst_r     <= cmd_dst;
              cmd_ready <= 1'b0;
              if (needs_src_s) begin
                rf_read_en <= src_oh_s;
                state_r    <= ST_READ;
              end else begin
                rf_write_en <= dst_oh_s;
                done        <= 1'b1;
                rf_datain   <= (cmd_op_s == OP_LOADI) ? cmd_imm : '0;
                state_r     <= ST_WRITE;
              end
            end
          end else begin
            err       <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end

        ST_READ: begin
          // Capture the source value at the end of the read cycle; INC wraps
          rf_read_en  <= '0;
          rf_write_en <= dst_oh_s;
          done        <= 1'b1;
          err         <= 1'b0;
          cmd_ready   <= 1'b0;
          if (op_r == OP_INC) begin
            rf_datain <= rf_dataout + REG_WIDTH'(1);
          end else begin
            rf_datain <= rf_dataout;
          end
          state_r <= ST_WRITE;
        end

        ST_WRITE: begin
          rf_read_en  <= '0;
          rf_write_en <= '0;
          done        <= 1'b0;
          err         <= 1'b0;
          cmd_ready   <= 1'b1;
          state_r     <= ST_IDLE;
        end

        default: begin
          rf_read_en  <= '0;
          rf_write_en <= '0;
          done        <= 1'b0;
          err         <= 1'b0;
          cmd_ready   <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
